// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: bundle between two requesters, the arbiter and an APB master.
//
// Requester side (two requesters; field i of each bus belongs to requester i):
//   req_start[1:0]         request, held until the matching req_ready
//   req_write[1:0]         direction, 1 = write
//   req_sel[3:0]           target slave id, [2i+1:2i]
//   req_addr/req_wdata/req_wait_cycles[15:0]  8-bit fields, [8i+7:8i]
//   req_ready[1:0]         one-cycle completion pulse
//   req_err[1:0]           error flag, valid with req_ready
//   req_rdata[7:0]         shared read data, valid with req_ready
// APB master side:
//   start, write, sel[1:0], addr, wdata, wait_cycles[7:0]  latched command
//   ready, rdata[7:0]      completion from the APB master
//   grant[1:0]             one-hot owner of the current transfer
//
// Modports: master = the arbiter, slave = requesters plus the APB master.
interface apb_req_arbiter_if;
  logic [1:0]  req_start;
  logic [1:0]  req_write;
  logic [3:0]  req_sel;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [15:0] req_wait_cycles;
  logic [1:0]  req_ready;
  logic [1:0]  req_err;
  logic [7:0]  req_rdata;
  logic        start;
  logic        write;
  logic [1:0]  sel;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  wait_cycles;
  logic        ready;
  logic [7:0]  rdata;
  logic [1:0]  grant;

  modport master (
    input  req_start, req_write, req_sel, req_addr, req_wdata, req_wait_cycles, ready, rdata,
    output req_ready, req_err, req_rdata, start, write, sel, addr, wdata, wait_cycles, grant
  );

  modport slave (
    output req_start, req_write, req_sel, req_addr, req_wdata, req_wait_cycles, ready, rdata,
    input  req_ready, req_err, req_rdata, start, write, sel, addr, wdata, wait_cycles, grant
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-requester round-robin arbiter in front of an APB master.
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    apb_req_arbiter_if.master (requester side and APB master side)
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles before a transfer is aborted with an error
// Configuration macro:
//   APB_ARB_TIMEOUT_EN  when defined, a WAIT-cycle counter aborts stalled transfers;
//                       when undefined, WAIT lasts until ready and no counter exists.
//
// Flow: IDLE -> ISSUE (start pulse) -> WAIT (until ready) -> DONE (req_ready pulse) -> IDLE.
// A granted sel of 00 jumps from IDLE straight to DONE with an error. All outputs registered.
module apb_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               reset,
  apb_req_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;  // index of the requester granted most recently
  logic [1:0] grant_q, grant_d;
  logic       start_q, start_d;
  logic       write_q, write_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] wait_cycles_q, wait_cycles_d;
  logic [1:0] req_ready_q, req_ready_d;
  logic [1:0] req_err_q, req_err_d;
  logic [7:0] req_rdata_q, req_rdata_d;

  logic       win;
  logic [1:0] win_oh;
  logic [1:0] win_sel;
  logic       timeout;

  // On a tie the requester not granted last wins; a lone request wins outright.
  assign win     = (bus.req_start == 2'b11) ? ~last_q : bus.req_start[1];
  assign win_oh  = win ? 2'b10 : 2'b01;
  assign win_sel = bus.req_sel[{win, 1'b0} +: 2];

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counts completed WAIT cycles; cleared whenever the FSM is elsewhere.
  always_comb begin
    cnt_d = '0;
    if (state_q == StWait) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      last_q        <= 1'b1;  // requester 0 wins the first tie
      grant_q       <= '0;
      start_q       <= 1'b0;
      write_q       <= 1'b0;
      sel_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wait_cycles_q <= '0;
      req_ready_q   <= '0;
      req_err_q     <= '0;
      req_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      start_q       <= start_d;
      write_q       <= write_d;
      sel_q         <= sel_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wait_cycles_q <= wait_cycles_d;
      req_ready_q   <= req_ready_d;
      req_err_q     <= req_err_d;
      req_rdata_q   <= req_rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.req_start) begin
          state_d = (win_sel == 2'b00) ? StDone : StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.ready || timeout) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    last_d        = last_q;
    grant_d       = grant_q;
    start_d       = 1'b0;
    write_d       = write_q;
    sel_d         = sel_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wait_cycles_d = wait_cycles_q;
    req_ready_d   = '0;
    req_err_d     = '0;
    req_rdata_d   = req_rdata_q;
    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        if (|bus.req_start) begin
          grant_d       = win_oh;
          last_d        = win;
          write_d       = bus.req_write[win];
          sel_d         = win_sel;
          addr_d        = bus.req_addr[{win, 3'b000} +: 8];
          wdata_d       = bus.req_wdata[{win, 3'b000} +: 8];
          wait_cycles_d = bus.req_wait_cycles[{win, 3'b000} +: 8];
          if (win_sel == 2'b00) begin
            req_ready_d = win_oh;
            req_err_d   = win_oh;
            req_rdata_d = 8'hFF;
          end else begin
            start_d = 1'b1;
          end
        end
      end
      StIssue: ;
      StWait: begin
        if (bus.ready) begin
          req_ready_d = grant_q;
          req_rdata_d = write_q ? 8'h00 : bus.rdata;
        end else if (timeout) begin
          req_ready_d = grant_q;
          req_err_d   = grant_q;
          req_rdata_d = 8'hFF;
        end
      end
      StDone:  grant_d = '0;
      default: grant_d = '0;
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.start       = start_q;
  assign bus.write       = write_q;
  assign bus.sel         = sel_q;
  assign bus.addr        = addr_q;
  assign bus.wdata       = wdata_q;
  assign bus.wait_cycles = wait_cycles_q;
  assign bus.req_ready   = req_ready_q;
  assign bus.req_err     = req_err_q;
  assign bus.req_rdata   = req_rdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a response scoreboard.
module tb_apb_req_arbiter;
  localparam int unsigned TimeoutCycles = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  apb_req_arbiter_if bus ();

  apb_req_arbiter #(
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int start_cnt = 0;

  typedef struct {
    logic [1:0] rdy;
    logic [1:0] err;
    logic [7:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  // APB master model.
  logic       auto_resp = 1'b1;
  int         resp_delay = 1;
  logic [7:0] resp_data = 8'h00;
  logic       resp_ready = 1'b0;
  logic       manual_ready = 1'b0;

  assign bus.ready = resp_ready | manual_ready;
  assign bus.rdata = resp_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] rdy, input logic [1:0] err, input logic [7:0] rd);
    exp_t e;
    e.rdy   = rdy;
    e.err   = err;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic w, input logic [1:0] s, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] wc);
    bus.req_write[i]               = w;
    bus.req_sel[2*i +: 2]          = s;
    bus.req_addr[8*i +: 8]         = a;
    bus.req_wdata[8*i +: 8]        = wd;
    bus.req_wait_cycles[8*i +: 8]  = wc;
  endtask

  // Returns #1 after the negedge at which a new req_ready was seen.
  task automatic wait_done(input string tag, input int budget);
    int base;
    base = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != base) break;
    end
    check(tag, done_cnt - base, 1);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (bus.grant != 2'b00) break;
    end
    check(tag, bus.grant, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always begin
    @(negedge clk);
    if (auto_resp && bus.start) begin
      repeat (resp_delay) @(negedge clk);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  end

  // Scoreboard: every req_ready pulse must match the oldest pending expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.start) start_cnt++;
    if (bus.req_ready != 2'b00) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_req_ready", bus.req_ready, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("req_ready", bus.req_ready, e.rdy);
        check("req_err", bus.req_err, e.err);
        check("req_rdata", bus.req_rdata, e.rdata);
        check("grant_in_done", bus.grant, e.rdy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int d0;
    bus.req_start       = '0;
    bus.req_write       = '0;
    bus.req_sel         = '0;
    bus.req_addr        = '0;
    bus.req_wdata       = '0;
    bus.req_wait_cycles = '0;

    // Asynchronous reset, checked before the first clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_grant", bus.grant, 2'b00);
    check("rst_start", bus.start, 1'b0);
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_req_err", bus.req_err, 2'b00);
    check("rst_req_rdata", bus.req_rdata, 8'h00);
    check("rst_addr", bus.addr, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Requester 0 read, ready three cycles into WAIT.
    @(negedge clk);
    set_req(0, 1'b0, 2'b01, 8'h10, 8'h33, 8'h07);
    resp_delay = 3;
    resp_data  = 8'h5A;
    push_exp(2'b01, 2'b00, 8'h5A);
    bus.req_start = 2'b01;
    @(negedge clk);
    #1;
    check("t1_grant", bus.grant, 2'b01);
    check("t1_start", bus.start, 1'b1);
    check("t1_addr", bus.addr, 8'h10);
    check("t1_sel", bus.sel, 2'b01);
    check("t1_wait_cycles", bus.wait_cycles, 8'h07);
    check("t1_write", bus.write, 1'b0);
    bus.req_addr[7:0] = 8'hEE;
    @(negedge clk);
    #1;
    check("t1_start_one_cycle", bus.start, 1'b0);
    check("t1_addr_held", bus.addr, 8'h10);
    wait_done("t1_done", 20);
    bus.req_start = 2'b00;
    @(negedge clk);
    #1;
    check("t1_grant_idle", bus.grant, 2'b00);
    check("t1_start_count", start_cnt, 1);

    // Simultaneous requests after reset: 0 first, then 1, then a repeat tie goes to 0.
    do_reset();
    @(negedge clk);
    set_req(0, 1'b0, 2'b01, 8'h20, 8'h00, 8'h00);
    set_req(1, 1'b1, 2'b10, 8'h30, 8'h77, 8'h01);
    resp_delay = 1;
    resp_data  = 8'hA5;
    push_exp(2'b01, 2'b00, 8'hA5);
    push_exp(2'b10, 2'b00, 8'h00);
    bus.req_start = 2'b11;
    @(negedge clk);
    #1;
    check("tie_first", bus.grant, 2'b01);
    wait_done("tie_done0", 20);
    bus.req_start[0] = 1'b0;
    wait_grant("tie_second", 2'b10, 10);
    check("tie_second_wdata", bus.wdata, 8'h77);
    check("tie_second_write", bus.write, 1'b1);
    wait_done("tie_done1", 20);
    bus.req_start[1] = 1'b0;
    @(negedge clk);
    push_exp(2'b01, 2'b00, 8'hA5);
    bus.req_start = 2'b11;
    wait_grant("tie_repeat", 2'b01, 10);
    wait_done("tie_repeat_done", 20);
    bus.req_start = 2'b00;  // requester 1 withdraws before being granted
    repeat (4) @(negedge clk);
    #1;
    check("withdrawn_no_grant", bus.grant, 2'b00);

    // Invalid sel: straight to DONE with an error, no start pulse.
    s0 = start_cnt;
    set_req(1, 1'b1, 2'b00, 8'h40, 8'h12, 8'h00);
    push_exp(2'b10, 2'b10, 8'hFF);
    bus.req_start = 2'b10;
    wait_done("badsel_done", 10);
    bus.req_start = 2'b00;
    check("badsel_no_start", start_cnt - s0, 0);

    // Requester 0 drops req_start one cycle after grant; transfer still completes.
    @(negedge clk);
    set_req(0, 1'b0, 2'b11, 8'h50, 8'h00, 8'h00);
    resp_delay = 2;
    resp_data  = 8'h3C;
    push_exp(2'b01, 2'b00, 8'h3C);
    bus.req_start = 2'b01;
    wait_grant("drop_grant", 2'b01, 5);
    @(negedge clk);
    bus.req_start = 2'b00;
    wait_done("drop_done", 20);

    // Stale ready in IDLE never completes anything.
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    manual_ready = 1'b1;
    repeat (3) @(negedge clk);
    manual_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("stale_ready_ignored", done_cnt - d0, 0);
    check("stale_ready_grant", bus.grant, 2'b00);

    // Reset during WAIT: outputs clear asynchronously, no response after release.
    auto_resp = 1'b0;
    set_req(0, 1'b0, 2'b01, 8'h60, 8'h00, 8'h09);
    bus.req_start = 2'b01;
    wait_grant("rst_wait_grant", 2'b01, 5);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_grant", bus.grant, 2'b00);
    check("rstw_addr", bus.addr, 8'h00);
    check("rstw_sel", bus.sel, 2'b00);
    check("rstw_wait_cycles", bus.wait_cycles, 8'h00);
    check("rstw_req_rdata", bus.req_rdata, 8'h00);
    bus.req_start = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    manual_ready = 1'b1;
    @(negedge clk);
    manual_ready = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("rstw_no_ready", done_cnt - d0, 0);

`ifdef APB_ARB_TIMEOUT_EN
    // Ready never arrives: abort after TimeoutCycles WAIT cycles.
    set_req(0, 1'b0, 2'b10, 8'h70, 8'h00, 8'h00);
    push_exp(2'b01, 2'b01, 8'hFF);
    bus.req_start = 2'b01;
    wait_done("timeout_done", 20);
    bus.req_start = 2'b00;
    d0 = done_cnt;
    @(negedge clk);
    manual_ready = 1'b1;
    repeat (3) @(negedge clk);
    manual_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("timeout_late_ready_ignored", done_cnt - d0, 0);
`else
    // Without the timeout, WAIT holds until ready finally arrives.
    set_req(0, 1'b0, 2'b10, 8'h70, 8'h00, 8'h00);
    bus.req_start = 2'b01;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    #1;
    check("wait_indefinite", done_cnt - d0, 0);
    check("wait_indefinite_grant", bus.grant, 2'b01);
    resp_data = 8'hC3;
    push_exp(2'b01, 2'b00, 8'hC3);
    manual_ready = 1'b1;
    wait_done("late_ready_done", 5);
    manual_ready = 1'b0;
    bus.req_start = 2'b00;
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: WAIT-state cycles before abort (used only with APB_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_start  in  2  per-requester request, held until that requester's req_ready.
REQ-005 SHALL have port req_write  in  2  per-requester direction, 1=write.
REQ-006 SHALL have port req_sel  in  4  target slave id, bits [2i+1:2i] for requester i.
REQ-007 SHALL have ports req_addr, req_wdata, req_wait_cycles  in  16 each  8-bit fields, bits [8i+7:8i] for requester i.
REQ-008 SHALL have port req_ready  out  2  one-cycle completion pulse per requester.
REQ-009 SHALL have port req_err  out  2  error flag, valid only with req_ready.
REQ-010 SHALL have port req_rdata  out  8  read data, shared by both requesters, valid with req_ready.
REQ-011 SHALL have ports start, write  out  1  and sel  out  2  driven to the APB master processor-bus side.
REQ-012 SHALL have ports addr, wdata, wait_cycles  out  8 each  latched fields to the APB master.
REQ-013 SHALL have ports ready  in  1  and rdata  in  8  from the APB master.
REQ-014 SHALL have port grant  out  2  one-hot owner of the current transfer, 00 when IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-016 SHALL, in IDLE with any req_start high, choose winner g and go to ISSUE next cycle.
REQ-017 SHALL resolve a tie round-robin: winner is the requester not granted last; the pointer updates only on grant.
REQ-018 SHALL latch write, sel, addr, wdata and wait_cycles of g on the grant edge; later requester changes are ignored until DONE.
REQ-019 SHALL drive start=1 for exactly the one ISSUE cycle, then go to WAIT.
REQ-020 SHALL, in WAIT, on sampling ready=1: capture rdata into req_rdata (writes capture 00), then go to DONE.
REQ-021 SHALL assert req_ready[g]=1 for exactly the one DONE cycle, then return to IDLE.
REQ-022 SHALL keep grant=g from ISSUE through DONE.
REQ-023 SHALL treat a granted req_sel of 00 as invalid: skip ISSUE/WAIT and go directly to DONE with req_err[g]=1, req_rdata=FF, start never asserted.
REQ-024 SHALL ignore ready when not in WAIT; a stale ready never produces req_ready.
REQ-025 SHALL end every transfer with IDLE for at least one cycle, so back-to-back transfers start no faster than every 4 cycles plus wait time.
REQ-026 SHALL treat req_start falling before grant as a withdrawn request with no response.
REQ-027 SHALL, if req_start falls after grant, still complete the transfer and pulse req_ready.

Reset
REQ-028 SHALL, on reset low, asynchronously enter IDLE and clear start, write, sel, addr, wdata, wait_cycles, grant, req_ready, req_err, req_rdata and the timeout counter.
REQ-029 SHALL set the round-robin pointer so that requester 0 wins the first tie.
REQ-030 SHALL, on reset mid-transfer, abort the transfer with no req_ready pulse.

Configuration
REQ-031 SHALL support macro APB_ARB_TIMEOUT_EN.
REQ-032 SHALL, with APB_ARB_TIMEOUT_EN defined, count WAIT cycles; when the count reaches TIMEOUT_CYCLES without ready, go to DONE with req_err[g]=1 and req_rdata=FF.
REQ-033 SHALL, with APB_ARB_TIMEOUT_EN undefined, contain no counter and wait in WAIT indefinitely.

Verification
REQ-034 SHALL cover: requester 0 read, sel=01, addr=10; ready with rdata=5A three cycles into WAIT -> start one cycle, req_ready=01, req_err=00, req_rdata=5A.
REQ-035 SHALL cover: both requesters start in the same cycle after reset -> grants 01 then 10; a repeated tie after that -> 01.
REQ-036 SHALL cover: requester 1 write, sel=00 -> no start pulse, req_ready=10, req_err=10, req_rdata=FF.
REQ-037 SHALL cover: reset low during WAIT -> all outputs 0 asynchronously, and no req_ready after release.
REQ-038 SHALL cover: with APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, ready held 0 -> req_err pulses with req_ready; a later ready=1 in IDLE is ignored.
REQ-039 SHALL cover: requester 0 drops req_start one cycle after grant -> transfer completes and req_ready[0] pulses.
